// File: rtl/prog_loader.sv
// Boot-time program loader: unpacks a framed big-endian byte stream into 16-bit
// memory words from address 0 and releases the cpu once the checksum verifies.
module prog_loader #(
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [15:0]           mem_value_o,
  output logic                  mem_enable_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  output logic                  cpu_rst_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO, DONE, ERR
  } state_t;

  // One extra counter bit lets a full-depth image (N == MEM_DEPTH) be represented.
  localparam int              CW          = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [16:0]     DEPTH_LIMIT = 17'(MEM_DEPTH);

  state_t                state;
  state_t                next_state;
  logic                  accept;
  logic [7:0]            hi_q;
  logic [15:0]           rx_word;
  logic [CW-1:0]         n_words;
  logic [CW-1:0]         idx;
  logic [15:0]           csum;
  logic                  hdr_too_big;
  logic                  last_word;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           value_q;

  assign rx_word     = {hi_q, byte_data_i};
  assign accept      = byte_valid_i & byte_ready_o;
  assign hdr_too_big = {1'b0, rx_word} > DEPTH_LIMIT;
  assign last_word   = (idx + CNT_ONE) == n_words;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= HDR_HI;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      HDR_HI: if (accept) next_state = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_too_big) begin
            next_state = ERR;
          end else if (rx_word == 16'h0000) begin
            next_state = CHK_HI;
          end else begin
            next_state = DAT_HI;
          end
        end
      end
      DAT_HI: if (accept) next_state = DAT_LO;
      DAT_LO: if (accept) next_state = last_word ? CHK_HI : DAT_HI;
      CHK_HI: if (accept) next_state = CHK_LO;
      // csum already holds the last word: it was added at least two cycles earlier.
      CHK_LO: if (accept) next_state = (rx_word == csum) ? DONE : ERR;
      DONE:   next_state = DONE;
      ERR:    next_state = ERR;
      default: next_state = HDR_HI;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    cpu_rst_o    = 1'b1;
    case (state)
      HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO: byte_ready_o = ~rst_i;
      DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = 1'b0;
      end
      ERR:  error_o = 1'b1;
      default: ;
    endcase
  end

  // Byte pairing, counters and the registered write port; address/data hold between writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q    <= '0;
      n_words <= '0;
      idx     <= '0;
      csum    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      wr_q <= 1'b0;
      if (accept) begin
        case (state)
          HDR_HI, DAT_HI, CHK_HI: hi_q <= byte_data_i;
          HDR_LO: n_words <= rx_word[CW-1:0];
          DAT_LO: begin
            wr_q    <= 1'b1;
            addr_q  <= idx[ADDR_WIDTH-1:0];
            value_q <= rx_word;
            csum    <= csum + rx_word;
            idx     <= idx + CNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_enable_o = wr_q;
  assign mem_wr_en_o  = wr_q;
  assign mem_rd_en_o  = 1'b0;
  assign mem_addr_o   = addr_q;
  assign mem_value_o  = value_q;

endmodule
